// File: rtl/transport_pkg.sv
// transport_pkg: header codes, session commands, FSM encoding and framing constants
// shared by the transmit and receive halves of the transport layer.
package transport_pkg;
   localparam int         VOICE_WORDS = 7;
   localparam logic [7:0] TRAILER     = 8'hFF;
   localparam logic [7:0] HDR_VOICE   = 8'h80;
   localparam logic [7:0] HDR_CTRL    = 8'h40;
   localparam logic [1:0] CMD_VOICE   = 2'b01;
   localparam logic [1:0] CMD_CTRL    = 2'b10;
   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_WAIT_NET, S_HEADER, S_PAYLOAD, S_TRAILER
   } state_e;
endpackage

// File: rtl/tsnd_word_buf.sv
// tsnd_word_buf: voice word register file with write pointer and a byte-select read
// port indexed by the payload byte counter (even index = high byte).
module tsnd_word_buf
   import transport_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        we_i,
   input  logic [15:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic [2:0]  count_o,
   output logic [7:0]  rdata_o
);
   logic [15:0] mem_q [VOICE_WORDS];
   logic [2:0]  ptr_q;
   logic [15:0] word;
   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         ptr_q <= '0;
         for (int i = 0; i < VOICE_WORDS; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[ptr_q] <= wdata_i;
         ptr_q        <= ptr_q + 3'd1;
      end
   end
   assign count_o = ptr_q;
   assign word    = (sel_i[3:1] < 3'(VOICE_WORDS)) ? mem_q[sel_i[3:1]] : '0;
   assign rdata_o = sel_i[0] ? word[7:0] : word[15:8];
endmodule

// File: rtl/transport_send.sv
// transport_send: packetizes session words into byte-serial voice/control packets.
// Define TRANSPORT_SEQ_NUM_EN to carry a 6-bit wrapping sequence number in header[5:0].
module transport_send
   import transport_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sessionValid_i,
   input  logic [1:0]  sessionCmd_i,
   input  logic [15:0] sessionData_i,
   input  logic        networkBusy_i,
   output logic        transportReady_o,
   output logic        sendSignal_o,
   output logic [7:0]  packetOut_o,
   output logic        txDone_o
);
   localparam logic [3:0] VOICE_LAST = 4'(2 * VOICE_WORDS);
   state_e      state_q;
   logic        send_q, done_q, ctrl_pend_q, kind_ctrl_q;
   logic [7:0]  pkt_q;
   logic [15:0] ctrl_word_q;
   logic [3:0]  bc_q;
   logic [2:0]  count;
   logic [7:0]  voice_byte, pay_byte, hdr;
   logic [3:0]  last;
   logic [5:0]  seq;
   logic        accept, voice_we, ctrl_we, buf_clr;

   assign transportReady_o = state_q == S_IDLE || state_q == S_COLLECT;
   assign accept   = sessionValid_i && transportReady_o;
   assign voice_we = accept && sessionCmd_i == CMD_VOICE;
   assign ctrl_we  = accept && sessionCmd_i == CMD_CTRL;
   assign buf_clr  = state_q == S_TRAILER && !kind_ctrl_q;
   assign last     = kind_ctrl_q ? 4'd2 : VOICE_LAST;
   assign pay_byte = kind_ctrl_q ? (bc_q[0] ? ctrl_word_q[7:0] : ctrl_word_q[15:8]) : voice_byte;
   assign hdr      = (ctrl_pend_q ? HDR_CTRL : HDR_VOICE) | {2'b00, seq};

`ifdef TRANSPORT_SEQ_NUM_EN
   logic [5:0] seq_q;
   always_ff @(posedge clk) begin
      if (reset) seq_q <= '0;
      else if (state_q == S_TRAILER) seq_q <= seq_q + 6'd1;
   end
   assign seq = seq_q;
`else
   assign seq = '0;
`endif

   tsnd_word_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (buf_clr),
      .we_i    (voice_we),
      .wdata_i (sessionData_i),
      .sel_i   (bc_q),
      .count_o (count),
      .rdata_o (voice_byte)
   );

   // Outputs are registered: each state names the byte currently on packetOut.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         send_q      <= 1'b0;
         pkt_q       <= '0;
         done_q      <= 1'b0;
         ctrl_pend_q <= 1'b0;
         kind_ctrl_q <= 1'b0;
         ctrl_word_q <= '0;
         bc_q        <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_COLLECT: begin
               if (ctrl_we) begin
                  ctrl_word_q <= sessionData_i;
                  ctrl_pend_q <= 1'b1;
                  state_q     <= S_WAIT_NET;
               end else if (voice_we) begin
                  state_q <= (count == 3'(VOICE_WORDS - 1)) ? S_WAIT_NET : S_COLLECT;
               end
            end
            S_WAIT_NET: begin
               if (!networkBusy_i) begin
                  state_q     <= S_HEADER;
                  send_q      <= 1'b1;
                  pkt_q       <= hdr;
                  kind_ctrl_q <= ctrl_pend_q;
                  bc_q        <= '0;
               end
            end
            S_HEADER, S_PAYLOAD: begin
               if (state_q == S_PAYLOAD && bc_q == last) begin
                  pkt_q   <= TRAILER;
                  state_q <= S_TRAILER;
               end else begin
                  pkt_q   <= pay_byte;
                  bc_q    <= bc_q + 4'd1;
                  state_q <= S_PAYLOAD;
               end
            end
            S_TRAILER: begin
               send_q  <= 1'b0;
               pkt_q   <= '0;
               done_q  <= 1'b1;
               if (kind_ctrl_q) ctrl_pend_q <= 1'b0;
               state_q <= (kind_ctrl_q && count != 3'd0) ? S_COLLECT : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sendSignal_o = send_q;
   assign packetOut_o  = pkt_q;
   assign txDone_o     = done_q;
endmodule

// File: tb/tb_transport_send.sv
// tb_transport_send: scoreboard bench; expected bytes are queued as words are offered
// and popped by a monitor whenever sendSignal is high.
module tb_transport_send;
   import transport_pkg::*;
   logic        clk = 1'b0, reset = 1'b1, sessionValid = 1'b0, networkBusy = 1'b0;
   logic [1:0]  sessionCmd = 2'b00;
   logic [15:0] sessionData = 16'h0;
   logic        transportReady, sendSignal, txDone;
   logic [7:0]  packetOut;
   logic [7:0]  exp_q [$];
   logic [7:0]  e;
   logic [15:0] vw [7];
   int          pass_cnt = 0, total_cnt = 0, tb_seq = 0;
   bit          seen, flag;
   int          len;

   transport_send dut (
      .clk              (clk),
      .reset            (reset),
      .sessionValid_i   (sessionValid),
      .sessionCmd_i     (sessionCmd),
      .sessionData_i    (sessionData),
      .networkBusy_i    (networkBusy),
      .transportReady_o (transportReady),
      .sendSignal_o     (sendSignal),
      .packetOut_o      (packetOut),
      .txDone_o         (txDone)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sendSignal) begin
         total_cnt++;
         if (exp_q.size() == 0) e = 8'hxx;
         else e = exp_q.pop_front();
         if (packetOut !== e) $display("FAIL pkt_byte got %h required %h", packetOut, e);
         else pass_cnt++;
      end
   end

   function automatic logic [7:0] hdr(input logic ctrl);
`ifdef TRANSPORT_SEQ_NUM_EN
      return (ctrl ? 8'h40 : 8'h80) | 8'(tb_seq % 64);
`else
      return ctrl ? 8'h40 : 8'h80;
`endif
   endfunction

   task automatic send_word(input logic [1:0] cmd, input logic [15:0] d);
      sessionValid = 1'b1; sessionCmd = cmd; sessionData = d;
      @(negedge clk);
      sessionValid = 1'b0; sessionCmd = 2'b00;
   endtask

   task automatic send_voice(input int first, input int n);
      for (int i = first; i < first + n; i++) send_word(CMD_VOICE, vw[i]);
   endtask

   task automatic push_voice();
      exp_q.push_back(hdr(1'b0));
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(vw[i][15:8]);
         exp_q.push_back(vw[i][7:0]);
      end
      exp_q.push_back(8'hFF);
   endtask

   task automatic push_ctrl(input logic [15:0] w);
      exp_q.push_back(hdr(1'b1));
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(8'hFF);
   endtask

   task automatic rand_words();
      for (int i = 0; i < 7; i++) vw[i] = 16'($urandom);
   endtask

   // Returns whether txDone arrived and the cycles from first sendSignal to txDone.
   task automatic wait_done(output bit s, output int l);
      int start;
      s = 1'b0; l = -1; start = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (sendSignal && start < 0) start = i;
         if (txDone) begin
            s = 1'b1; l = i - start; tb_seq++;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt += 4;
      if (sendSignal !== 1'b0) $display("FAIL rst_send got %b required 0", sendSignal); else pass_cnt++;
      if (packetOut !== 8'h00) $display("FAIL rst_pkt got %h required 00", packetOut); else pass_cnt++;
      if (txDone !== 1'b0) $display("FAIL rst_done got %b required 0", txDone); else pass_cnt++;
      if (transportReady !== 1'b1) $display("FAIL rst_ready got %b required 1", transportReady); else pass_cnt++;
      reset = 1'b0; tb_seq = 0;
   endtask

   task automatic test_voice();
      vw = '{16'h0405, 16'h0607, 16'h0809, 16'h1011, 16'h1213, 16'h1415, 16'h1617};
      push_voice();
      send_voice(0, 7);
      wait_done(seen, len);
      total_cnt += 6;
      if (seen !== 1'b1) $display("FAIL voice_done got %b required 1", seen); else pass_cnt++;
      if (len != 16) $display("FAIL voice_len got %0d required 16", len); else pass_cnt++;
      if (exp_q.size() != 0) $display("FAIL voice_left got %0d required 0", exp_q.size()); else pass_cnt++;
      if (sendSignal !== 1'b0) $display("FAIL voice_send_end got %b required 0", sendSignal); else pass_cnt++;
      @(negedge clk);
      if (txDone !== 1'b0) $display("FAIL voice_done_pulse got %b required 0", txDone); else pass_cnt++;
      if (transportReady !== 1'b1) $display("FAIL voice_ready got %b required 1", transportReady); else pass_cnt++;
   endtask

   task automatic test_control();
      push_ctrl(16'h0202);
      send_word(CMD_CTRL, 16'h0202);
      wait_done(seen, len);
      total_cnt += 5;
      if (seen !== 1'b1) $display("FAIL ctrl_done got %b required 1", seen); else pass_cnt++;
      if (len != 4) $display("FAIL ctrl_len got %0d required 4", len); else pass_cnt++;
      if (exp_q.size() != 0) $display("FAIL ctrl_left got %0d required 0", exp_q.size()); else pass_cnt++;
      @(negedge clk);
      send_word(2'b00, 16'h1111);
      send_word(2'b11, 16'h2222);
      flag = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (sendSignal !== 1'b0) flag = 1'b1;
      end
      if (flag) $display("FAIL ignored_cmd got send=1 required send=0"); else pass_cnt++;
      if (transportReady !== 1'b1) $display("FAIL ctrl_idle_ready got %b required 1", transportReady); else pass_cnt++;
   endtask

   task automatic test_busy();
      networkBusy = 1'b1;
      rand_words();
      push_voice();
      send_voice(0, 7);
      flag = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (sendSignal !== 1'b0 || transportReady !== 1'b0) flag = 1'b1;
      end
      send_word(CMD_CTRL, 16'hDEAD);
      networkBusy = 1'b0;
      @(negedge clk); #1;
      total_cnt += 5;
      if (flag) $display("FAIL busy_hold got send/ready active required both 0"); else pass_cnt++;
      if (sendSignal !== 1'b1) $display("FAIL busy_release_send got %b required 1", sendSignal); else pass_cnt++;
      if (packetOut !== hdr(1'b0)) $display("FAIL busy_release_hdr got %h required %h", packetOut, hdr(1'b0)); else pass_cnt++;
      wait_done(seen, len);
      if (seen !== 1'b1) $display("FAIL busy_done got %b required 1", seen); else pass_cnt++;
      if (exp_q.size() != 0) $display("FAIL busy_left got %0d required 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_preempt();
      vw = '{16'h1A2B, 16'h3C4D, 16'h5E6F, 16'h7081, 16'h92A3, 16'hB4C5, 16'hD6E7};
      send_voice(0, 3);
      push_ctrl(16'hABCD);
      send_word(CMD_CTRL, 16'hABCD);
      wait_done(seen, len);
      total_cnt += 6;
      if (seen !== 1'b1) $display("FAIL pre_ctrl_done got %b required 1", seen); else pass_cnt++;
      if (len != 4) $display("FAIL pre_ctrl_len got %0d required 4", len); else pass_cnt++;
      if (transportReady !== 1'b1) $display("FAIL pre_ready got %b required 1", transportReady); else pass_cnt++;
      push_voice();
      send_voice(3, 4);
      wait_done(seen, len);
      if (seen !== 1'b1) $display("FAIL pre_voice_done got %b required 1", seen); else pass_cnt++;
      if (len != 16) $display("FAIL pre_voice_len got %0d required 16", len); else pass_cnt++;
      if (exp_q.size() != 0) $display("FAIL pre_left got %0d required 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      rand_words();
      push_voice();
      send_voice(0, 7);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() <= 10) break;
      end
      reset = 1'b1;
      @(negedge clk);
      total_cnt += 4;
      if (exp_q.size() != 10) $display("FAIL mid_progress got %0d required 10", exp_q.size()); else pass_cnt++;
      if (sendSignal !== 1'b0) $display("FAIL mid_send got %b required 0", sendSignal); else pass_cnt++;
      if (packetOut !== 8'h00) $display("FAIL mid_pkt got %h required 00", packetOut); else pass_cnt++;
      if (txDone !== 1'b0) $display("FAIL mid_done got %b required 0", txDone); else pass_cnt++;
      reset = 1'b0; tb_seq = 0;
      exp_q.delete();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         rand_words();
         push_voice();
         send_voice(0, 7);
         wait_done(seen, len);
         @(negedge clk);
         total_cnt += 2;
         if (seen !== 1'b1 || len != 16) $display("FAIL clean_voice%0d got done=%b len=%0d required done=1 len=16", k, seen, len); else pass_cnt++;
         if (exp_q.size() != 0) $display("FAIL clean_left%0d got %0d required 0", k, exp_q.size()); else pass_cnt++;
      end
      push_ctrl(16'h5AA5);
      send_word(CMD_CTRL, 16'h5AA5);
      wait_done(seen, len);
      total_cnt += 2;
      if (seen !== 1'b1 || len != 4) $display("FAIL clean_ctrl got done=%b len=%0d required done=1 len=4", seen, len); else pass_cnt++;
      if (exp_q.size() != 0) $display("FAIL clean_ctrl_left got %0d required 0", exp_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_voice();
      test_control();
      test_busy();
      test_preempt();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
